// File: rtl/uart_mm_host.sv
// Avalon-MM master for uart_mm_top. It programs the baud divider and control
// register, then polls status and moves bytes between the TX/RX streams and the FIFOs.
module uart_mm_host #(
  parameter logic [31:0] baud_limit = 32'd434,
  parameter logic [31:0] ctrl_init  = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        avmm_write_o,
  output logic        avmm_read_o,
  output logic [2:0]  avmm_address_o,
  output logic [31:0] avmm_writedata_o,
  output logic [3:0]  avmm_byteenable_o,
  input  logic        avmm_waitrequest_i,
  input  logic [31:0] avmm_readdata_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_perr_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        init_done_o
);

  typedef enum logic [2:0] {
    INIT_BAUD, INIT_CTRL, POLL, TX_WR, RX_RD, RX_OUT
  } state_t;

  localparam logic [2:0] ADDR_CTRL = 3'h0;
  localparam logic [2:0] ADDR_BAUD = 3'h1;
  localparam logic [2:0] ADDR_TXF  = 3'h4;
  localparam logic [2:0] ADDR_RXF  = 3'h5;

  state_t state;
  logic   rr;
  logic   rx_cand;
  logic   tx_cand;
  logic   unused_rdata;

  // Status bits are only meaningful in the cycle a POLL read completes.
  assign rx_cand      = ~avmm_readdata_i[0];
  assign tx_cand      = tx_valid_i & ~avmm_readdata_i[3];
  assign tx_ready_o   = (state == TX_WR) & ~avmm_waitrequest_i;
  assign unused_rdata = ^avmm_readdata_i[31:9];

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= INIT_BAUD;
      rr                <= 1'b0;
      avmm_write_o      <= 1'b0;
      avmm_read_o       <= 1'b0;
      avmm_address_o    <= 3'h0;
      avmm_writedata_o  <= 32'h0;
      avmm_byteenable_o <= 4'h0;
      rx_data_o         <= 8'h0;
      rx_perr_o         <= 1'b0;
      rx_valid_o        <= 1'b0;
      init_done_o       <= 1'b0;
    end else begin
      case (state)
        INIT_BAUD: begin
          if (!avmm_write_o) begin
            avmm_write_o      <= 1'b1;
            avmm_address_o    <= ADDR_BAUD;
            avmm_writedata_o  <= baud_limit;
            avmm_byteenable_o <= 4'hF;
          end else if (!avmm_waitrequest_i) begin
            avmm_address_o   <= ADDR_CTRL;
            avmm_writedata_o <= ctrl_init;
            state            <= INIT_CTRL;
          end
        end
        INIT_CTRL: begin
          if (!avmm_waitrequest_i) begin
            avmm_write_o     <= 1'b0;
            avmm_read_o      <= 1'b1;
            avmm_address_o   <= ADDR_CTRL;
            avmm_writedata_o <= 32'h0;
            init_done_o      <= 1'b1;
            state            <= POLL;
          end
        end
        POLL: begin
          // With no candidate the read stays asserted, so a fresh poll follows.
          if (!avmm_waitrequest_i) begin
            if (rx_cand && (!tx_cand || !rr)) begin
              avmm_address_o <= ADDR_RXF;
              state          <= RX_RD;
            end else if (tx_cand) begin
              avmm_read_o      <= 1'b0;
              avmm_write_o     <= 1'b1;
              avmm_address_o   <= ADDR_TXF;
              avmm_writedata_o <= {24'h0, tx_data_i};
              state            <= TX_WR;
            end
          end
        end
        TX_WR: begin
          if (!avmm_waitrequest_i) begin
            avmm_write_o     <= 1'b0;
            avmm_read_o      <= 1'b1;
            avmm_address_o   <= ADDR_CTRL;
            avmm_writedata_o <= 32'h0;
            rr               <= 1'b0;
            state            <= POLL;
          end
        end
        RX_RD: begin
          if (!avmm_waitrequest_i) begin
            avmm_read_o              <= 1'b0;
            avmm_byteenable_o        <= 4'h0;
            {rx_perr_o, rx_data_o}   <= avmm_readdata_i[8:0];
            rx_valid_o               <= 1'b1;
            rr                       <= 1'b1;
            state                    <= RX_OUT;
          end
        end
        RX_OUT: begin
          if (rx_ready_i) begin
            rx_valid_o        <= 1'b0;
            avmm_read_o       <= 1'b1;
            avmm_address_o    <= ADDR_CTRL;
            avmm_byteenable_o <= 4'hF;
            state             <= POLL;
          end
        end
        default: state <= INIT_BAUD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mm_host.sv
// Self-checking bench for uart_mm_host: a queue-based model of the UART peripheral
// and of both byte streams, directed scenarios, then a randomized traffic phase.
module tb_uart_mm_host;
  localparam int TX_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        avmm_write_o, avmm_read_o;
  logic [2:0]  avmm_address_o;
  logic [31:0] avmm_writedata_o;
  logic [3:0]  avmm_byteenable_o;
  logic        avmm_waitrequest_i = 1'b0;
  logic [31:0] avmm_readdata_i = '0;
  logic [7:0]  tx_data_i = '0;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o;
  logic [7:0]  rx_data_o;
  logic        rx_perr_o, rx_valid_o;
  logic        rx_ready_i = 1'b0;
  logic        init_done_o;

  uart_mm_host dut (
    .clk(clk), .reset(reset),
    .avmm_write_o(avmm_write_o), .avmm_read_o(avmm_read_o),
    .avmm_address_o(avmm_address_o), .avmm_writedata_o(avmm_writedata_o),
    .avmm_byteenable_o(avmm_byteenable_o), .avmm_waitrequest_i(avmm_waitrequest_i),
    .avmm_readdata_i(avmm_readdata_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_perr_o(rx_perr_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .init_done_o(init_done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Peripheral and stream model
  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] src_q[$];
  int         order_q[$];
  int tx_cnt = 0, rx_budget = 0;
  int wait_pct = 0, rx_ready_pct = 100, tx_pct = 0, drain_pct = 0, arrive_pct = 0;
  bit force_wait = 0, tx_acc = 0;
  int ready_cnt = 0, wr4_cnt = 0, delivered = 0;
  logic [7:0] last_wr4 = '0;

  logic        s_rd, s_wr, s_be_dummy;
  logic [2:0]  s_addr;
  logic [31:0] s_wd;
  logic [3:0]  s_be;
  logic        s_rxv, s_rxp, s_idone;
  logic [7:0]  s_rxd;
  logic        p_stall = 0, p_rd, p_wr, p_hold = 0;
  logic [2:0]  p_addr;
  logic [31:0] p_wd;
  logic [8:0]  p_rx9;

  // One clock cycle: sample at the falling edge, act as slave/stream partner.
  task automatic step();
    bit w, comp;
    @(negedge clk);
    s_rd = avmm_read_o;  s_wr = avmm_write_o;  s_addr = avmm_address_o;
    s_wd = avmm_writedata_o;  s_be = avmm_byteenable_o;
    s_rxv = rx_valid_o;  s_rxd = rx_data_o;  s_rxp = rx_perr_o;  s_idone = init_done_o;
    if (tx_acc) begin
      tx_valid_i = 1'b0;
      tx_acc = 0;
    end
    if (reset) begin
      p_stall = 0; p_hold = 0;
      avmm_waitrequest_i = 1'b0;
      rx_ready_i = 1'b0;
      return;
    end
    check("cmd_excl", s_rd & s_wr, 0);
    check("byteenable", s_be, (s_rd | s_wr) ? 4'hF : 4'h0);
    if (p_stall) check("cmd_hold", {s_rd, s_wr, s_addr, s_wd}, {p_rd, p_wr, p_addr, p_wd});
    if (s_rxv) check("rxout_quiet", s_rd | s_wr, 0);
    if (p_hold) check("rx_hold", {s_rxv, s_rxp, s_rxd}, {1'b1, p_rx9});

    w = force_wait || ($urandom_range(0, 99) < wait_pct);
    avmm_waitrequest_i = w;
    comp = (s_rd | s_wr) && !w;
    avmm_readdata_i = '0;
    if (s_rd && s_addr == 3'h0)
      avmm_readdata_i = {28'h0, tx_cnt >= TX_DEPTH, 2'b00, rx_q.size() == 0};
    else if (s_rd && s_addr == 3'h5 && rx_q.size() > 0)
      avmm_readdata_i = {23'h0, rx_q[0]};

    if (comp && s_wr && s_addr == 3'h4) begin
      check("tx_overflow", tx_cnt < TX_DEPTH, 1);
      check("tx_valid_at_wr", tx_valid_i, 1);
      if (src_q.size() > 0) begin
        check("tx_wdata", s_wd, {24'h0, src_q[0]});
        void'(src_q.pop_front());
      end
      tx_cnt++; wr4_cnt++; last_wr4 = s_wd[7:0];
      order_q.push_back(4);
      tx_acc = 1;
    end
    if (comp && s_rd && s_addr == 3'h5) begin
      check("rx_underflow", rx_q.size() > 0, 1);
      if (rx_q.size() > 0) exp_q.push_back(rx_q.pop_front());
      order_q.push_back(5);
    end

    if (tx_cnt > 0 && $urandom_range(0, 99) < drain_pct) tx_cnt--;
    if (rx_budget > 0 && $urandom_range(0, 99) < arrive_pct) begin
      rx_q.push_back(9'($urandom));
      rx_budget--;
    end
    if (!tx_acc && !tx_valid_i && src_q.size() > 0 && $urandom_range(0, 99) < tx_pct) begin
      tx_valid_i = 1'b1;
      tx_data_i = src_q[0];
    end

    rx_ready_i = ($urandom_range(0, 99) < rx_ready_pct);
    if (s_rxv && rx_ready_i) begin
      check("rx_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("rx_data", {s_rxp, s_rxd}, exp_q.pop_front());
      delivered++;
    end
    p_hold = s_rxv && !rx_ready_i;
    p_rx9 = {s_rxp, s_rxd};

    #1;
    check("tx_ready", tx_ready_o, comp && s_wr && s_addr == 3'h4);
    if (tx_ready_o) ready_cnt++;
    p_stall = (s_rd | s_wr) && w;
    p_rd = s_rd; p_wr = s_wr; p_addr = s_addr; p_wd = s_wd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tx_valid_i = 1'b0;
    tx_acc = 0;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int r0, w0, d0, n;

    // Reset values and init sequence
    do_reset();
    check("reset_outs", {s_rd, s_wr, s_addr, s_wd, s_be, s_rxv, s_rxd, s_rxp, s_idone}, 0);
    check("reset_tx_ready", tx_ready_o, 0);
    step();
    check("c1_cmd", {s_rd, s_wr, s_addr}, {1'b0, 1'b1, 3'h1});
    check("c1_data", s_wd, 32'd434);
    check("c1_idone", s_idone, 0);
    step();
    check("c2_cmd", {s_rd, s_wr, s_addr}, {1'b0, 1'b1, 3'h0});
    check("c2_data", s_wd, 32'h3000);
    check("c2_idone", s_idone, 0);
    step();
    check("c3_cmd", {s_rd, s_wr, s_addr}, {1'b1, 1'b0, 3'h0});
    check("c3_idone", s_idone, 1);
    step();
    check("c4_cmd", {s_rd, s_wr, s_addr}, {1'b1, 1'b0, 3'h0});

    // Single TX byte with RX empty
    tx_pct = 100;
    src_q.push_back(8'hA5);
    r0 = ready_cnt; w0 = wr4_cnt;
    repeat (6) step();
    check("tx_one_pulse", ready_cnt - r0, 1);
    check("tx_one_write", wr4_cnt - w0, 1);
    check("tx_one_byte", last_wr4, 8'hA5);

    // TX FIFO full blocks the write until it drains
    tx_cnt = TX_DEPTH;
    src_q.push_back(8'h3C);
    r0 = ready_cnt; w0 = wr4_cnt;
    repeat (10) step();
    check("txfull_no_write", wr4_cnt - w0, 0);
    check("txfull_no_ready", ready_cnt - r0, 0);
    tx_cnt = 0;
    repeat (5) step();
    check("txfree_write", wr4_cnt - w0, 1);
    check("txfree_byte", last_wr4, 8'h3C);

    // RX byte with parity flag, held while downstream stalls
    rx_ready_pct = 0;
    rx_q.push_back(9'h1C3);
    d0 = delivered;
    n = 0;
    while (!s_rxv && n < 10) begin
      step();
      n++;
    end
    check("rx_latency", n, 3);
    repeat (5) begin
      step();
      check("rx_stall_valid", s_rxv, 1);
      check("rx_stall_data", {s_rxp, s_rxd}, 9'h1C3);
      check("rx_stall_quiet", s_rd | s_wr, 0);
    end
    rx_ready_pct = 100;
    step();
    check("rx_delivered", delivered - d0, 1);
    step();
    check("rx_valid_drop", s_rxv, 0);

    // Round-robin when both sides have work
    rx_q.push_back(9'h012);
    rx_q.push_back(9'h034);
    src_q.push_back(8'h56);
    src_q.push_back(8'h78);
    order_q.delete();
    do_reset();
    repeat (16) step();
    check("rr_count", order_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check("rr_order", (i < order_q.size()) ? order_q[i] : 0, (i % 2 == 0) ? 5 : 4);

    // Reset while INIT_CTRL is stalled
    tx_pct = 0;
    do_reset();
    step();
    check("rst_c1_cmd", {s_wr, s_addr}, {1'b1, 3'h1});
    force_wait = 1;
    repeat (3) step();
    check("rst_stall_cmd", {s_wr, s_addr, s_wd}, {1'b1, 3'h0, 32'h3000});
    reset = 1'b1;
    step();
    check("rst_outs_zero", {s_rd, s_wr, s_addr, s_wd, s_be, s_rxv, s_idone}, 0);
    force_wait = 0;
    reset = 1'b0;
    step();
    check("rst_restart_cmd", {s_rd, s_wr, s_addr, s_wd}, {1'b0, 1'b1, 3'h1, 32'd434});
    check("rst_restart_idone", s_idone, 0);
    step();
    step();
    check("rst_init_done", s_idone, 1);

    // Randomized traffic with wait states, back-pressure and FIFO drain
    tx_cnt = 0;
    wait_pct = 30; rx_ready_pct = 50; tx_pct = 60; drain_pct = 40; arrive_pct = 20;
    rx_budget = 40;
    for (int i = 0; i < 40; i++) src_q.push_back(8'($urandom));
    d0 = delivered; w0 = wr4_cnt;
    for (int i = 0; i < 20000; i++) begin
      step();
      if (rx_budget == 0 && rx_q.size() == 0 && exp_q.size() == 0 && src_q.size() == 0 &&
          !s_rxv && !tx_valid_i) break;
    end
    check("rand_rx_delivered", delivered - d0, 40);
    check("rand_tx_written", wr4_cnt - w0, 40);
    check("rand_src_drained", src_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_mm_host.md
# uart_mm_host

Avalon-MM master that drives the UART register-mapped peripheral (uart_mm_top) from a pair of byte streams. After reset it programs the baud divider and control register. It then continuously polls the CONTROL status bits, pushes bytes from an upstream TX stream into the TX FIFO (address 0x4), and pops bytes from the RX FIFO (address 0x5) onto a downstream RX stream with a parity-error flag. It sits directly on the peripheral's Avalon slave port, so packet and protocol logic can use plain valid/ready streams.

## Interface

Parameters:
- baud_limit, 32'd434 — value written to BAUD_GEN (0x1) during init (50 MHz / 115200).
- ctrl_init, 32'h0000_3000 — value written to CONTROL (0x0) during init: bits [13:8] = {rx_en, tx_en, sbit[1:0], ptype, pbit}; default enables TX/RX, no parity, 1 stop bit.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- avmm_write_o  out  1  Avalon write.
- avmm_read_o  out  1  Avalon read.
- avmm_address_o  out  3  word address.
- avmm_writedata_o  out  32  write data.
- avmm_byteenable_o  out  4  always 4'hF while a transaction is active, else 4'h0.
- avmm_waitrequest_i  in  1  slave stall.
- avmm_readdata_i  in  32  read data; valid in the completing cycle.
- tx_data_i  in  8  byte to transmit.
- tx_valid_i  in  1  tx_data_i valid; must stay stable until accepted.
- tx_ready_o  out  1  byte accepted this cycle.
- rx_data_o  out  8  received byte.
- rx_perr_o  out  1  parity error flag for rx_data_o (FIFO bit 8).
- rx_valid_o  out  1  rx_data_o/rx_perr_o valid.
- rx_ready_i  in  1  downstream accepts.
- init_done_o  out  1  high once both init writes have completed.

## Operation

- An Avalon transaction completes in a cycle where (read|write) and !avmm_waitrequest_i. Address, data and command are held stable until completion. Read and write are never asserted together. At most one transaction is outstanding.
- FSM states: INIT_BAUD, INIT_CTRL, POLL, TX_WR, RX_RD, RX_OUT.
  - INIT_BAUD: write 0x1 = baud_limit; on completion go to INIT_CTRL.
  - INIT_CTRL: write 0x0 = ctrl_init; on completion set init_done_o and go to POLL.
  - POLL: read 0x0. On completion, latch rx_empty=readdata[0] and tx_full=readdata[3].
    - rx_cand = !rx_empty; tx_cand = tx_valid_i & !tx_full.
    - Both candidates: choose by the rr bit (rr=0 → RX_RD, rr=1 → TX_WR).
    - One candidate: take it.
    - Neither: remain in POLL and issue a new read the next cycle.
  - TX_WR: write 0x4 = {24'b0, tx_data_i}. tx_ready_o = (state==TX_WR) & !avmm_waitrequest_i. On completion set rr←0 and go to POLL.
  - RX_RD: read 0x5. On completion register {rx_perr_o, rx_data_o} ← readdata[8:0], set rr←1, go to RX_OUT.
  - RX_OUT: rx_valid_o=1 with data held. When rx_ready_i=1, go to POLL. There is no Avalon activity in this state.
- A stale status snapshot is safe by design:
  - Only this block writes the TX FIFO, so tx_full cannot become falsely clear.
  - Only this block reads the RX FIFO, so rx_empty can only become falsely set, which just delays service.
- tx_valid_i dropping before acceptance is a protocol violation by upstream. The behaviour is undefined, but the FSM must not hang: TX_WR still completes and writes whatever byte is on tx_data_i.

## Timing

- Reset values: all Avalon outputs 0; tx_ready_o=0; rx_valid_o=0; rx_data_o=0; rx_perr_o=0; init_done_o=0; rr=0; state INIT_BAUD.
- Reset is sampled at the clock edge. Asserting it mid-transaction drops all outputs in the following cycle, discards a captured RX byte, and restarts init.
- Command outputs are registered from state. A new transaction is issued the cycle after the previous one completes.
- With zero wait states: init takes 2 cycles; each POLL read takes 1 cycle.
  - TX byte: POLL + TX_WR = 2 cycles per byte.
  - RX byte: POLL + RX_RD + RX_OUT(≥1) = 3 cycles minimum per byte.
- Wait states extend the relevant state cycle-for-cycle.
- rx_valid_o rises the cycle after RX_RD completes. It is held, with data stable, until rx_ready_i is high.

## Test plan

- Reset, waitrequest=0 → write 0x1=434 in cycle 1, write 0x0=0x3000 in cycle 2, init_done_o=1 from cycle 3, then continuous reads of 0x0.
- Status=0x1 (rx empty), tx_valid_i=1 with data 0xA5 → write 0x4 data 0x0000_00A5 with tx_ready_o pulsed for exactly 1 cycle.
- Status=0x8 (tx full), tx_valid_i=1 → no write to 0x4 and tx_ready_o=0 until status returns 0x0, then the write occurs.
- Status=0x0 with 0x5 returning 0x1C3 → rx_data_o=0xC3, rx_perr_o=1. With rx_ready_i held low for 5 cycles, valid and data stay stable and no Avalon traffic occurs.
- Both candidates present for 4 consecutive polls → serviced in the order RX, TX, RX, TX.
- waitrequest held high for 3 cycles during INIT_CTRL, then reset asserted → outputs 0 the next cycle and the sequence restarts at the 0x1 write.
